// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: owns the single-port frame RAM and shares it between the
// UART row writer and the VGA read path. An accepted row is latched whole into
// a buffer, then streamed into RAM one pixel per free cycle. VGA reads always
// win the port; a pending write simply waits on the same pixel.
module frame_ram_arbiter #(
  parameter int WIGHT   = 640,
  parameter int HEIGHT  = 480,
  parameter int PIX_W   = 3,
  parameter int ADDR_W  = 19,
  parameter int RAM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     row_done,
  input  logic [8:0]               row_idx,
  input  logic [PIX_W*WIGHT-1:0]   row_data,
  output logic                     row_busy,
  output logic                     row_ovf,
  input  logic                     ovf_clr,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [PIX_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [PIX_W-1:0]         ram_data,
  output logic                     ram_wren,
  input  logic [PIX_W-1:0]         ram_q,
  output logic [15:0]              rows_written
);

  localparam int K_W = $clog2(WIGHT);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state;
  logic [K_W-1:0]     k;
  logic [ADDR_W-1:0]  base;
  logic [PIX_W-1:0]   pix_buf [WIGHT];
  logic [RAM_LAT:0]   vld_p;

  logic               row_accept;
  logic               ovf_set;
  logic               last_pix;
  logic [ADDR_W-1:0]  base_next;

  // A row is taken only when idle and its index lies inside the frame;
  // every other row_done pulse is a dropped row.
  assign row_accept = row_done && (state == IDLE) && (32'(row_idx) < 32'(HEIGHT));
  assign ovf_set    = row_done && !row_accept;
  assign last_pix   = (k == K_W'(WIGHT - 1));
  // Row start address: full-width product, truncated to the RAM address width.
  assign base_next  = ADDR_W'(32'(row_idx) * 32'(WIGHT));

  // Control FSM, RAM port arbitration, overflow flag and row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row_busy     <= 1'b0;
      row_ovf      <= 1'b0;
      k            <= '0;
      base         <= '0;
      ram_addr     <= '0;
      ram_data     <= '0;
      ram_wren     <= 1'b0;
      rows_written <= '0;
    end else begin
      // Setting beats clearing when both happen in one cycle.
      if (ovf_set) begin
        row_ovf <= 1'b1;
      end else if (ovf_clr) begin
        row_ovf <= 1'b0;
      end

      // Reads own the port; a write only goes out in a cycle without a read.
      if (rd_req) begin
        ram_addr <= rd_addr;
        ram_wren <= 1'b0;
      end else if (state == WRITE) begin
        ram_addr <= base + ADDR_W'(k);
        ram_data <= pix_buf[k];
        ram_wren <= 1'b1;
        k        <= k + 1'b1;
      end else begin
        ram_wren <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (row_accept) begin
            base     <= base_next;
            k        <= '0;
            state    <= WRITE;
            row_busy <= 1'b1;
          end
        end
        WRITE: begin
          if (!rd_req && last_pix) begin
            state        <= IDLE;
            row_busy     <= 1'b0;
            rows_written <= rows_written + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row buffer: captured whole on acceptance, untouched by dropped rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIGHT; i++) pix_buf[i] <= '0;
    end else if (row_accept) begin
      for (int i = 0; i < WIGHT; i++) pix_buf[i] <= row_data[PIX_W*i +: PIX_W];
    end
  end

  // Read return pipeline: vld_p[0] marks the address edge, vld_p[RAM_LAT]
  // marks ram_q valid; rd_data/rd_valid register it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_p    <= {vld_p[RAM_LAT-1:0], rd_req};
      rd_valid <= vld_p[RAM_LAT];
      if (vld_p[RAM_LAT]) begin
        rd_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Testbench for frame_ram_arbiter: a behavioural two-cycle-latency frame RAM,
// directed stimulus pushing expected writes/reads into queues, and a monitor
// that pops and compares whenever the DUT writes RAM or returns read data.
module tb_frame_ram_arbiter;

  localparam int WIGHT   = 640;
  localparam int HEIGHT  = 480;
  localparam int PIX_W   = 3;
  localparam int ADDR_W  = 19;
  localparam int RAM_LAT = 2;
  localparam int NPIX    = WIGHT * HEIGHT;

  logic                   clk;
  logic                   rst_n;
  logic                   row_done;
  logic [8:0]             row_idx;
  logic [PIX_W*WIGHT-1:0] row_data;
  logic                   row_busy;
  logic                   row_ovf;
  logic                   ovf_clr;
  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_valid;
  logic [PIX_W-1:0]       rd_data;
  logic [ADDR_W-1:0]      ram_addr;
  logic [PIX_W-1:0]       ram_data;
  logic                   ram_wren;
  logic [PIX_W-1:0]       ram_q;
  logic [15:0]            rows_written;

  frame_ram_arbiter #(
    .WIGHT(WIGHT), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_done(row_done), .row_idx(row_idx),
    .row_data(row_data), .row_busy(row_busy), .row_ovf(row_ovf),
    .ovf_clr(ovf_clr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .rows_written(rows_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM model: address registered, then output registered (2 cycles).
  logic [PIX_W-1:0] mem [NPIX];
  logic [PIX_W-1:0] q_p1;
  bit               mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < NPIX; i++) mem[i] = PIX_W'(i % 8);
      mem_init = 1'b1;
    end
    q_p1  <= (int'(ram_addr) < NPIX) ? mem[ram_addr] : '0;
    ram_q <= q_p1;
    if (ram_wren && int'(ram_addr) < NPIX) mem[ram_addr] = ram_data;
  end

  int checks = 0;
  int passes = 0;
  int wr_cnt = 0;
  int last_wa = -1;
  int exp_wa[$];
  int exp_wd[$];
  int exp_rd[$];
  int exp_rc[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every RAM write and every read return is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wren) begin
        wr_cnt++;
        last_wa = int'(ram_addr);
        if (exp_wa.size() == 0) begin
          checks++;
          $display("FAIL wr_unexpected: got write addr=%0d data=%0d, required no write",
                   ram_addr, ram_data);
        end else begin
          check("wr_addr", ram_addr, exp_wa.pop_front());
          check("wr_data", ram_data, exp_wd.pop_front());
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL rd_unexpected: got rd_valid with data=%0d, required none", rd_data);
        end else begin
          check("rd_data", rd_data, exp_rd.pop_front());
          check("rd_latency", cyc - exp_rc.pop_front(), RAM_LAT + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one row for one cycle; if it should be accepted, queue its writes.
  task automatic send_row(input int idx, input int seed, input bit accept);
    logic [PIX_W*WIGHT-1:0] d;
    for (int p = 0; p < WIGHT; p++) d[PIX_W*p +: PIX_W] = PIX_W'((p + seed) % 8);
    row_idx  = 9'(idx);
    row_data = d;
    row_done = 1'b1;
    if (accept) begin
      for (int p = 0; p < WIGHT; p++) begin
        exp_wa.push_back(idx * WIGHT + p);
        exp_wd.push_back((p + seed) % 8);
      end
    end
    tick();
    row_done = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (row_busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_busy"}, row_busy, 0);
    check({tag, "_row_ovf"}, row_ovf, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_data"}, ram_data, 0);
    check({tag, "_ram_wren"}, ram_wren, 0);
    check({tag, "_rows_written"}, rows_written, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int w0;
    int w1;
    int exp_rows;
    rst_n = 1'b0; row_done = 1'b0; row_idx = '0; row_data = '0;
    ovf_clr = 1'b0; rd_req = 1'b0; rd_addr = '0;
    exp_rows = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");

    // Row 2, pixel k = k mod 8, no reads.
    w0 = wr_cnt;
    send_row(2, 0, 1'b1);
    wait_idle(n);
    check("t1_busy_cycles", n, 640);
    repeat (2) tick();
    check("t1_wr_cycles", wr_cnt - w0, 640);
    check("t1_last_addr", last_wa, 1919);
    exp_rows++;
    check("t1_rows_written", rows_written, exp_rows);

    // Same row with a read of address 5 every other cycle.
    w0 = wr_cnt;
    send_row(2, 3, 1'b1);
    n = 0;
    while (row_busy && n < 5000) begin
      rd_req  = (n % 2 == 0);
      rd_addr = 19'd5;
      if (rd_req) begin
        exp_rd.push_back(int'(mem[5]));
        exp_rc.push_back(cyc + 1);
      end
      tick();
      n++;
    end
    rd_req = 1'b0;
    check("t2_busy_cycles", n, 1280);
    repeat (6) tick();
    check("t2_wr_cycles", wr_cnt - w0, 640);
    check("t2_reads_drained", exp_rd.size(), 0);
    exp_rows++;
    check("t2_rows_written", rows_written, exp_rows);

    // Last row of the frame, then an out-of-range row.
    send_row(479, 1, 1'b1);
    wait_idle(n);
    check("t3_busy_cycles", n, 640);
    repeat (2) tick();
    check("t3_last_addr", last_wa, 307199);
    exp_rows++;
    check("t3_rows_written", rows_written, exp_rows);
    w0 = wr_cnt;
    send_row(480, 2, 1'b0);
    repeat (20) tick();
    check("t3_oob_writes", wr_cnt - w0, 0);
    check("t3_oob_ovf", row_ovf, 1);
    check("t3_oob_busy", row_busy, 0);
    check("t3_oob_rows", rows_written, exp_rows);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", row_ovf, 0);

    // Second row mid-write: dropped, first row intact.
    send_row(10, 4, 1'b1);
    repeat (100) tick();
    send_row(11, 5, 1'b0);
    check("t4_mid_ovf", row_ovf, 1);
    wait_idle(n);
    check("t4_busy_rest", n, 539);
    repeat (2) tick();
    exp_rows++;
    check("t4_rows_written", rows_written, exp_rows);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", row_ovf, 0);

    // Second row exactly in the cycle of the last pixel write.
    send_row(12, 6, 1'b1);
    repeat (639) tick();
    send_row(13, 7, 1'b0);
    check("t4_last_busy", row_busy, 0);
    check("t4_last_ovf", row_ovf, 1);
    repeat (2) tick();
    exp_rows++;
    check("t4_last_rows", rows_written, exp_rows);

    // ovf_clr held while a new overflow arrives: set wins.
    ovf_clr = 1'b1;
    tick();
    check("t4_clr_held", row_ovf, 0);
    send_row(480, 0, 1'b0);
    check("t4_set_beats_clr", row_ovf, 1);
    tick();
    check("t4_clr_after", row_ovf, 0);
    ovf_clr = 1'b0;

    // Reads held for 1000 cycles mid-row: writes stall, then resume at the same pixel.
    send_row(20, 1, 1'b1);
    repeat (200) tick();
    rd_req  = 1'b1;
    rd_addr = 19'd7;
    w1 = wr_cnt;
    for (int i = 0; i < 1000; i++) begin
      exp_rd.push_back(int'(mem[7]));
      exp_rc.push_back(cyc + 1);
      tick();
      if (i == 0) w1 = wr_cnt;
    end
    check("t5_stalled_writes", wr_cnt - w1, 0);
    check("t5_busy_during_stall", row_busy, 1);
    rd_req = 1'b0;
    wait_idle(n);
    check("t5_busy_rest", n, 440);
    repeat (6) tick();
    exp_rows++;
    check("t5_rows_written", rows_written, exp_rows);
    check("t5_reads_drained", exp_rd.size(), 0);

    // Reset at pixel 300: everything returns to reset values at once.
    send_row(30, 2, 1'b1);
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_wa.delete();
    exp_wd.delete();
    exp_rd.delete();
    exp_rc.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_rows = 0;
    check("t6_rows_after_reset", rows_written, exp_rows);
    send_row(31, 3, 1'b1);
    wait_idle(n);
    check("t6_busy_cycles", n, 640);
    repeat (2) tick();
    check("t6_last_addr", last_wa, 31 * WIGHT + 639);
    exp_rows++;
    check("t6_rows_written", rows_written, exp_rows);

    repeat (5) tick();
    check("end_wr_queue_empty", exp_wa.size(), 0);
    check("end_rd_queue_empty", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
Owns the single-port frame RAM (WIGHT x HEIGHT pixels, PIX_W bits each) and shares it between two requesters. The UART row writer hands over one complete row per transfer. The VGA read path issues one pixel read per cycle. The block latches each accepted row into an internal buffer and sequences it into RAM pixel by pixel, with VGA reads always taking priority. This replaces the direct write/read address mux in front of the frame RAM.

Parameters:
WIGHT, 640, pixels per row
HEIGHT, 480, rows per frame
PIX_W, 3, bits per pixel (palette index)
ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= WIGHT*HEIGHT
RAM_LAT, 2, RAM read latency in cycles from the address at the RAM pins to valid ram_q

Ports:
clk  in  1  single clock for all logic; also the RAM clock
rst_n  in  1  asynchronous active-low reset
row_done  in  1  one-cycle pulse; row_idx and row_data are valid in this cycle
row_idx  in  9  target row index
row_data  in  PIX_W*WIGHT  packed row; pixel k = row_data[PIX_W*k +: PIX_W]
row_busy  out  1  high while a row is being written (state WRITE)
row_ovf  out  1  sticky error flag: a row was dropped
ovf_clr  in  1  clears row_ovf
rd_req  in  1  VGA read request, one per cycle
rd_addr  in  ADDR_W  VGA read address
rd_valid  out  1  rd_data valid
rd_data  out  PIX_W  returned pixel
ram_addr  out  ADDR_W  registered RAM address
ram_data  out  PIX_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
ram_q  in  PIX_W  RAM read data
rows_written  out  16  count of completed rows; wraps at 2^16

Behaviour:
- Reset (async assert, sync release): state IDLE. row_busy=0, row_ovf=0, rd_valid=0, rd_data=0, ram_addr=0, ram_data=0, ram_wren=0, rows_written=0. The read pipeline and the row buffer are cleared.
- States: IDLE and WRITE.
- IDLE, on row_done=1 with row_idx<HEIGHT:
  - copy row_data into the internal buffer;
  - set base = row_idx*WIGHT, computed at full width and truncated to ADDR_W;
  - set pixel counter k=0;
  - go to WRITE; row_busy=1 from the next cycle.
- IDLE, on row_done=1 with row_idx>=HEIGHT: row is dropped, row_ovf set, state stays IDLE.
- WRITE, on row_done=1: row is dropped and row_ovf set. This includes the cycle of the final pixel write. The buffer is not disturbed.
- Port arbitration, evaluated each cycle; outputs take effect on the next edge:
  - rd_req=1: ram_addr<=rd_addr, ram_wren<=0. Any pending write stalls and k holds.
  - else, in WRITE: ram_addr<=base+k, ram_data<=pixel k of the buffer, ram_wren<=1, k<=k+1.
  - else: ram_wren<=0 and ram_addr holds.
- Row completion: after the write of k=WIGHT-1 is issued:
  - state returns to IDLE and row_busy drops on the following cycle;
  - rows_written increments once;
  - a new row is accepted at the earliest on the first cycle row_busy=0.
- Read latency: a rd_req sampled high at edge N yields rd_valid=1 and rd_data=ram_q in the cycle starting at edge N+1+RAM_LAT. Back-to-back requests produce back-to-back valids in order. rd_valid=0 in all other cycles.
- Minimum row duration: WIGHT write cycles. Each cycle with rd_req=1 during WRITE adds one cycle.
- Starvation: with rd_req held high permanently, writes never issue. This is accepted; the VGA blanking intervals guarantee progress.
- row_ovf: ovf_clr clears it. If a set and ovf_clr occur in the same cycle, set wins.
- Reset mid-WRITE: the partial row is abandoned, the RAM keeps the pixels already written, and no rows_written increment occurs.

Test Plan:
- Reset, then row_done with row_idx=2 and pixel k = k mod 8, rd_req=0:
  - ram_wren high for exactly 640 consecutive cycles, addresses 1280..1919, data k mod 8;
  - rows_written=1; row_busy high for 640 cycles.
- Same row, with rd_req asserted every other cycle at rd_addr=5:
  - writes interleave with reads and the row finishes in 1280 cycles;
  - each rd_valid arrives 3 cycles after its request, with rd_data equal to the model RAM content at address 5.
- row_done with row_idx=479: the last write lands at address 307199. row_done with row_idx=480: no writes, row_ovf=1, rows_written unchanged.
- Second row_done during WRITE, including the cycle of the last pixel: row dropped, row_ovf=1, first row completes intact. ovf_clr then clears the flag. ovf_clr held while a new overflow occurs: flag stays 1.
- rd_req held high for 1000 cycles during WRITE: zero write cycles and k frozen. After release the row resumes at the stalled pixel with no gaps or duplicates.
- Assert rst_n=0 at pixel 300 of a row: all outputs are at reset values immediately. After release the next row_done is accepted normally and rows_written counts from 0.
